// File: rtl/switch_debounce_pkg.sv
// Shared constants and helpers for the slide-switch synchronizer/debouncer.
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH_DEFAULT        = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

  // Bits needed to hold a count from 0 up to 'cycles'.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit synchronizer chain, stability counter, clean level and change pulse.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic changed
);

  localparam int unsigned     CntW    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   changed_q, changed_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous level into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts the count.
  always_comb begin
    cnt_d     = cnt_q;
    clean_d   = clean_q;
    changed_d = 1'b0;
    if (sync == clean_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      clean_d   = sync;
      cnt_d     = '0;
      changed_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter, clean level and change pulse state.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      changed_q <= changed_d;
    end
  end

  assign clean   = clean_q;
  assign changed = changed_q;

endmodule

// File: rtl/switch_debounce_sync.sv
// Per-bit synchronizer/debouncer for the board slide switches, feeding the switches PIO.
// Define SWITCH_EDGE_CAPTURE_EN to build the sticky edge-capture register; otherwise
// edge_capture reads 0 and edge_clear is ignored.
module switch_debounce_sync
  import switch_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset  (reset),
      .raw    (sw_raw[i]),
      .clean  (sw_clean[i]),
      .changed(sw_changed[i])
    );
  end

`ifdef SWITCH_EDGE_CAPTURE_EN
  logic [WIDTH-1:0] capture_q, capture_d;

  // Set from the change pulse takes priority over a same-cycle clear.
  always_comb begin
    capture_d = (capture_q & ~edge_clear) | sw_changed;
  end

  // Sticky capture flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      capture_q <= '0;
    end else begin
      capture_q <= capture_d;
    end
  end

  assign edge_capture = capture_q;
`else
  logic unused_edge_clear;
  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
`endif

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Directed self-checking bench for switch_debounce_sync (WIDTH=10, 2 sync stages, 4 cycles).
module tb_switch_debounce_sync;

  localparam int unsigned WIDTH = 10;
`ifdef SWITCH_EDGE_CAPTURE_EN
  localparam bit CapEn = 1'b1;
`else
  localparam bit CapEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_changed;
  logic [WIDTH-1:0] edge_clear;
  logic [WIDTH-1:0] edge_capture;

  int n_checks = 0;
  int n_errors = 0;

  switch_debounce_sync #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_raw      (sw_raw),
    .sw_clean    (sw_clean),
    .sw_changed  (sw_changed),
    .edge_clear  (edge_clear),
    .edge_capture(edge_capture)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] cap(input logic [WIDTH-1:0] v);
    return CapEn ? v : '0;
  endfunction

  initial begin
    reset      = 1'b1;
    sw_raw     = '0;
    edge_clear = '0;

    // 1. reset
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_clean", sw_clean, 10'h000);
    check_eq("rst_changed", sw_changed, 10'h000);
    check_eq("rst_capture", edge_capture, 10'h000);
    reset = 1'b0;

    // 2. clean rise on bit 0: update on the 6th edge
    sw_raw = 10'h001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("rise_clean", sw_clean, (k >= 6) ? 10'h001 : 10'h000);
      check_eq("rise_changed", sw_changed, (k == 6) ? 10'h001 : 10'h000);
      check_eq("rise_capture", edge_capture, (k == 7) ? cap(10'h001) : 10'h000);
    end

    // 3. 3-cycle glitch on bit 3 is rejected
    sw_raw = 10'h009;
    for (int k = 0; k < 3; k++) tick();
    sw_raw = 10'h001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("glitch_changed", sw_changed, 10'h000);
      check_eq("glitch_clean", sw_clean, 10'h001);
    end

    // 4. bounce on bit 9, then settle high
    for (int i = 0; i < 20; i++) begin
      sw_raw[9] = ((i / 2) % 2) == 0;
      tick();
      check_eq("bounce_changed", sw_changed, 10'h000);
    end
    sw_raw[9] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq("settle_changed", sw_changed, (k == 6) ? 10'h200 : 10'h000);
    end
    check_eq("settle_clean", sw_clean, 10'h201);

    // 5a. both bits fall together, then all ten rise together
    sw_raw = 10'h000;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("fall_changed", sw_changed, (k == 6) ? 10'h201 : 10'h000);
    end
    check_eq("fall_clean", sw_clean, 10'h000);
    sw_raw = 10'h3FF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("all_changed", sw_changed, (k == 6) ? 10'h3FF : 10'h000);
      check_eq("all_clean", sw_clean, (k >= 6) ? 10'h3FF : 10'h000);
    end

    // 5b. reset two cycles into a count restarts it from release
    sw_raw = 10'h0F0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();
    check_eq("midrst_clean", sw_clean, 10'h000);
    check_eq("midrst_capture", edge_capture, 10'h000);
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_eq("midrst_changed", sw_changed, (k == 6) ? 10'h0F0 : 10'h000);
      check_eq("midrst_clean2", sw_clean, (k >= 6) ? 10'h0F0 : 10'h000);
    end
    check_eq("midrst_cap", edge_capture, cap(10'h0F0));

    // 6. edge capture clear and set-wins
    edge_clear = 10'h3FF;
    tick();
    edge_clear = 10'h000;
    check_eq("cap_cleared", edge_capture, 10'h000);
    sw_raw = 10'h0F1;
    for (int k = 1; k <= 6; k++) tick();
    check_eq("cap_pulse", sw_changed, 10'h001);
    edge_clear = 10'h001;
    tick();
    edge_clear = 10'h000;
    check_eq("cap_setwins", edge_capture, cap(10'h001));
    tick();
    check_eq("cap_hold", edge_capture, cap(10'h001));
    edge_clear = 10'h001;
    tick();
    edge_clear = 10'h000;
    check_eq("cap_clear", edge_capture, 10'h000);
    check_eq("final_clean", sw_clean, 10'h0F1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
